// File: rtl/uart_rx_fifo_port_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver state encoding and the helpers that turn the clock
// frequency and line rate into bit-period counts, so uart_tx can use the same
// derivation.
// No ports: this is a package.
package uart_rx_fifo_port_pkg;

  // Receiver state encoding, 3 bits wide.
  typedef enum logic [2:0] {
    RESYNC = 3'd0,
    IDLE   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    STOP   = 3'd4
  } rxState_t;

  // Clock cycles per serial bit. Integer division truncates, so the bit time
  // runs slightly short of ideal. A 10-bit frame tolerates that easily.
  function automatic int clksPerBit(input int clkFrequency, input int baud);
    return clkFrequency / baud;
  endfunction

  // Offset from the start-bit edge to the middle of the start bit.
  function automatic int halfBit(input int clkFrequency, input int baud);
    return clksPerBit(clkFrequency, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_port_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   i_clk     - destination clock
//   i_reset_n - synchronous active-low reset; both flops load RESET_VALUE
//   i_d       - asynchronous input
//   o_q       - synchronized output, two clocks behind i_d
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // The first flop may go metastable. The second flop gives it a full cycle to
  // settle before anything downstream reads the value.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_fifo_port.sv
// UART 8N1 receiver front end with a single-entry holding register.
// It recovers bytes from the raw rxd pin and offers each one on a valid/ready
// port. Framing and overrun errors appear as one-cycle pulses.
// Ports:
//   i_clk_12mhz    - system clock; all logic runs on the rising edge
//   i_reset_n      - synchronous active-low reset
//   i_rxd          - asynchronous serial input; idles high
//   o_data[7:0]    - received byte; meaningful while o_data_valid is high
//   o_data_valid   - holding register full
//   i_data_ready   - consumer takes the byte when valid and ready meet at an edge
//   o_frame_err    - one-cycle pulse when the stop bit is sampled low
//   o_overrun      - one-cycle pulse when a finished byte finds the register full
//   o_busy         - high from start-bit detect until the stop-bit sample
module uart_rx_fifo_port
  import uart_rx_fifo_port_pkg::*;
#(
  parameter int CLK_FREQUENCY = 12_000_000,
  parameter int BAUD          = 115_200
) (
  input  logic       i_clk_12mhz,
  input  logic       i_reset_n,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  input  logic       i_data_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQUENCY, BAUD);
  localparam int HALF_BIT     = halfBit(CLK_FREQUENCY, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);

  rxState_t         r_state;
  rxState_t         w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             r_deliver;
  logic [7:0]       r_data;
  logic             r_dataValid;
  logic             r_frameErr;
  logic             r_overrun;

  logic w_rxS;
  logic w_cntClr;
  logic w_cntInc;
  logic w_bitIdxClr;
  logic w_sampleData;
  logic w_stopGood;
  logic w_stopBad;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .i_clk     (i_clk_12mhz),
    .i_reset_n (i_reset_n),
    .i_d       (i_rxd),
    .o_q       (w_rxS)
  );

  // State register.
  always_ff @(posedge i_clk_12mhz) begin
    if (!i_reset_n) begin
      r_state <= RESYNC;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath strobes. Each counter compare fires on the edge
  // where the count reaches the target minus one, so the sample lands exactly
  // HALF_BIT or CLKS_PER_BIT edges after the counter was cleared.
  always_comb begin
    w_nextState  = r_state;
    w_cntClr     = 1'b0;
    w_cntInc     = 1'b0;
    w_bitIdxClr  = 1'b0;
    w_sampleData = 1'b0;
    w_stopGood   = 1'b0;
    w_stopBad    = 1'b0;
    unique case (r_state)
      RESYNC: begin
        // Require a full bit time of idle line before trusting a falling edge.
        // Otherwise we could lock onto a data bit in the middle of a frame.
        if (!w_rxS) begin
          w_cntClr = 1'b1;
        end else if (r_cnt == CNT_BIT_LAST) begin
          w_cntClr    = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_cntInc = 1'b1;
        end
      end
      IDLE: begin
        if (!w_rxS) begin
          w_cntClr    = 1'b1;
          w_nextState = START;
        end
      end
      START: begin
        w_bitIdxClr = 1'b1;
        if (r_cnt == CNT_HALF_LAST) begin
          w_cntClr    = 1'b1;
          w_nextState = w_rxS ? IDLE : DATA;
        end else begin
          w_cntInc = 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == CNT_BIT_LAST) begin
          w_cntClr     = 1'b1;
          w_sampleData = 1'b1;
          if (r_bitIdx == 3'd7) begin
            w_nextState = STOP;
          end
        end else begin
          w_cntInc = 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == CNT_BIT_LAST) begin
          w_cntClr = 1'b1;
          if (w_rxS) begin
            w_stopGood  = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_stopBad   = 1'b1;
            w_nextState = RESYNC;
          end
        end else begin
          w_cntInc = 1'b1;
        end
      end
      default: begin
        w_cntClr    = 1'b1;
        w_nextState = RESYNC;
      end
    endcase
  end

  // Counters, shifter and holding register. Delivery is one cycle after the
  // stop sample. At that edge the consumer's ready decides between a
  // replace-on-accept and a dropped byte that raises overrun.
  always_ff @(posedge i_clk_12mhz) begin
    if (!i_reset_n) begin
      r_cnt       <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_deliver   <= 1'b0;
      r_data      <= '0;
      r_dataValid <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_cntClr) begin
        r_cnt <= '0;
      end else if (w_cntInc) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_bitIdxClr) begin
        r_bitIdx <= '0;
      end else if (w_sampleData) begin
        r_bitIdx <= r_bitIdx + 1'b1;
      end

      if (w_sampleData) begin
        r_shift <= {w_rxS, r_shift[7:1]};
      end

      r_deliver  <= w_stopGood;
      r_frameErr <= w_stopBad;
      r_overrun  <= 1'b0;

      if (r_deliver) begin
        if (!r_dataValid || i_data_ready) begin
          r_data      <= r_shift;
          r_dataValid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_dataValid && i_data_ready) begin
        r_dataValid <= 1'b0;
      end
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_dataValid;
  assign o_frame_err  = r_frameErr;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state == START) || (r_state == DATA) || (r_state == STOP);

endmodule

// File: tb/tb_uart_rx_fifo_port.sv
// Self-checking bench for uart_rx_fifo_port at its default parameters.
// A frame-level model predicts the outputs: each frame sent schedules busy,
// delivery or framing-error events at fixed offsets from its start edge, and
// a one-entry holding register resolves each delivery against data_ready.
// A compare process checks the DUT against the model every cycle. Directed
// checks pin the model with hand-computed values.
module tb_uart_rx_fifo_port;

  localparam int BIT_CLKS = 104;
  localparam int EV_BUSY_ON  = 0;
  localparam int EV_BUSY_OFF = 1;
  localparam int EV_DELIVER  = 2;
  localparam int EV_FERR     = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       rxd = 1'b1;
  logic       dataReady = 1'b0;
  logic [7:0] dutData;
  logic       dutValid;
  logic       dutFerr;
  logic       dutOvr;
  logic       dutBusy;

  ev_t        evq[$];
  ev_t        restQ[$];
  int         cyc = 0;
  logic [7:0] mData = 8'h00;
  logic       mValid = 1'b0;
  logic       mFerr = 1'b0;
  logic       mOvr = 1'b0;
  logic       mBusy = 1'b0;
  logic       mDeliver;
  logic [7:0] mByte;

  int         checks = 0;
  int         errors = 0;
  int         framesSent = 0;
  int         lastStart = 0;
  int         ferrCount = 0;
  int         ovrCount = 0;
  int         riseCount = 0;
  int         busyCycles = 0;
  int         lastRiseCyc = 0;
  logic [7:0] riseData = 8'h00;
  logic       prevValid = 1'b0;

  uart_rx_fifo_port dut (
    .i_clk_12mhz  (clk),
    .i_reset_n    (resetN),
    .i_rxd        (rxd),
    .o_data       (dutData),
    .o_data_valid (dutValid),
    .i_data_ready (dataReady),
    .o_frame_err  (dutFerr),
    .o_overrun    (dutOvr),
    .o_busy       (dutBusy)
  );

  // 82 ns period, approximately 12 MHz.
  always #41 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, actual, expected);
    end
  endtask

  function automatic void addEvent(input int c, input int kind, input logic [7:0] d);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.d    = d;
    evq.push_back(e);
  endfunction

  // Frame-level model. The sync pipeline plus the edge-detect cycle puts the
  // start detect 3 edges after the line falls. The stop sample is at
  // 3 + 52 + 9*104 = 991, and delivery is one edge later, at 992.
  always @(posedge clk) begin
    cyc++;
    mFerr = 1'b0;
    mOvr  = 1'b0;
    if (!resetN) begin
      mValid = 1'b0;
      mData  = 8'h00;
      mBusy  = 1'b0;
      evq.delete();
    end else begin
      mDeliver = 1'b0;
      mByte    = 8'h00;
      restQ.delete();
      foreach (evq[i]) begin
        if (evq[i].cyc == cyc) begin
          case (evq[i].kind)
            EV_BUSY_ON:  mBusy = 1'b1;
            EV_BUSY_OFF: mBusy = 1'b0;
            EV_FERR:     mFerr = 1'b1;
            default: begin
              mDeliver = 1'b1;
              mByte    = evq[i].d;
            end
          endcase
        end else begin
          restQ.push_back(evq[i]);
        end
      end
      evq = restQ;
      if (mDeliver) begin
        if (!mValid || dataReady) begin
          mData  = mByte;
          mValid = 1'b1;
        end else begin
          mOvr = 1'b1;
        end
      end else if (mValid && dataReady) begin
        mValid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse and edge bookkeeping.
  always @(negedge clk) begin
    if (cyc > 0) begin
      checkOutput("data_valid", 32'(dutValid), 32'(mValid));
      checkOutput("data", 32'(dutData), 32'(mData));
      checkOutput("frame_err", 32'(dutFerr), 32'(mFerr));
      checkOutput("overrun", 32'(dutOvr), 32'(mOvr));
      checkOutput("busy", 32'(dutBusy), 32'(mBusy));
      if (dutFerr === 1'b1) ferrCount++;
      if (dutOvr === 1'b1) ovrCount++;
      if (dutBusy === 1'b1) busyCycles++;
      if (dutValid === 1'b1 && prevValid !== 1'b1) begin
        riseCount++;
        lastRiseCyc = cyc;
        riseData    = dutData;
      end
      prevValid = dutValid;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame and records the events the model should expect.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    int c0;
    @(posedge clk);
    #1;
    c0 = cyc;
    framesSent++;
    lastStart = c0;
    addEvent(c0 + 3, EV_BUSY_ON, 8'h00);
    addEvent(c0 + 991, EV_BUSY_OFF, 8'h00);
    if (stopBit) addEvent(c0 + 992, EV_DELIVER, b);
    else         addEvent(c0 + 991, EV_FERR, 8'h00);
    rxd = 1'b0;
    waitCycles(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      waitCycles(BIT_CLKS);
    end
    rxd = stopBit;
    waitCycles(BIT_CLKS);
    rxd = 1'b1;
  endtask

  // A short low glitch. The start-bit re-sample at edge 55 sees a high line.
  task automatic applyFalseStart(input int lowCycles);
    int c0;
    @(posedge clk);
    #1;
    c0 = cyc;
    addEvent(c0 + 3, EV_BUSY_ON, 8'h00);
    addEvent(c0 + 55, EV_BUSY_OFF, 8'h00);
    rxd = 1'b0;
    waitCycles(lowCycles);
    rxd = 1'b1;
  endtask

  initial begin
    #(82 * 60000);
    errors++;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int base;
    int rises0;
    int ferr0;
    int ovr0;
    int busy0;
    bit hit;

    // Reset.
    resetN    = 1'b0;
    rxd       = 1'b1;
    dataReady = 1'b0;
    waitCycles(3);
    checkOutput("reset data_valid", 32'(dutValid), 32'd0);
    checkOutput("reset busy", 32'(dutBusy), 32'd0);
    resetN = 1'b1;

    // Test 1: 0x55 with the consumer always ready.
    dataReady = 1'b1;
    waitCycles(200);
    rises0 = riseCount;
    ferr0  = ferrCount;
    ovr0   = ovrCount;
    applyStimulus(8'h55, 1'b1);
    base = lastStart;
    waitCycles(10);
    checkOutput("t1 rise count", 32'(riseCount - rises0), 32'd1);
    checkOutput("t1 latency", 32'(lastRiseCyc - base), 32'd992);
    checkOutput("t1 byte", 32'(riseData), 32'h55);
    checkOutput("t1 no pulses", 32'((ferrCount - ferr0) + (ovrCount - ovr0)), 32'd0);

    // Test 2: false start, then 0xA3.
    waitCycles(50);
    busy0  = busyCycles;
    rises0 = riseCount;
    ferr0  = ferrCount;
    applyFalseStart(20);
    waitCycles(100);
    checkOutput("t2 busy cycles", 32'(busyCycles - busy0), 32'd52);
    checkOutput("t2 no valid", 32'(riseCount - rises0), 32'd0);
    checkOutput("t2 no frame_err", 32'(ferrCount - ferr0), 32'd0);
    applyStimulus(8'hA3, 1'b1);
    waitCycles(10);
    checkOutput("t2 byte", 32'(riseData), 32'hA3);

    // Test 3: stop bit low, then 0x3C after resync.
    waitCycles(50);
    rises0 = riseCount;
    ferr0  = ferrCount;
    applyStimulus(8'hA5, 1'b0);
    waitCycles(300);
    checkOutput("t3 frame_err pulses", 32'(ferrCount - ferr0), 32'd1);
    checkOutput("t3 no valid", 32'(riseCount - rises0), 32'd0);
    applyStimulus(8'h3C, 1'b1);
    waitCycles(10);
    checkOutput("t3 byte", 32'(riseData), 32'h3C);

    // Test 4: consumer stalled across two back-to-back bytes.
    dataReady = 1'b0;
    waitCycles(50);
    ovr0 = ovrCount;
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    waitCycles(20);
    checkOutput("t4 held valid", 32'(dutValid), 32'd1);
    checkOutput("t4 held data", 32'(dutData), 32'h11);
    checkOutput("t4 overrun pulses", 32'(ovrCount - ovr0), 32'd1);
    dataReady = 1'b1;
    waitCycles(1);
    dataReady = 1'b0;
    waitCycles(2);
    checkOutput("t4 valid after accept", 32'(dutValid), 32'd0);
    checkOutput("t4 data kept", 32'(dutData), 32'h11);

    // Test 5: ready arrives exactly in the cycle the second byte is delivered.
    waitCycles(50);
    ovr0 = ovrCount;
    base = framesSent;
    hit  = 1'b0;
    fork
      begin
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
      end
      begin
        for (int k = 0; k < 4000; k++) begin
          @(posedge clk);
          #1;
          if (framesSent == base + 2 && cyc == lastStart + 991) begin
            dataReady = 1'b1;
            @(posedge clk);
            #1;
            dataReady = 1'b0;
            hit = 1'b1;
            break;
          end
        end
      end
    join
    checkOutput("t5 ready raised in time", 32'(hit), 32'd1);
    waitCycles(20);
    checkOutput("t5 valid stays", 32'(dutValid), 32'd1);
    checkOutput("t5 data", 32'(dutData), 32'h22);
    checkOutput("t5 model data", 32'(mData), 32'h22);
    checkOutput("t5 no overrun", 32'(ovrCount - ovr0), 32'd0);
    dataReady = 1'b1;
    waitCycles(3);
    checkOutput("t5 drained", 32'(dutValid), 32'd0);

    // Test 6: reset in the middle of bit 4 of 0xF0, then 0x81.
    waitCycles(50);
    base   = framesSent;
    rises0 = riseCount;
    hit    = 1'b0;
    fork
      applyStimulus(8'hF0, 1'b1);
      begin
        for (int k = 0; k < 2000; k++) begin
          @(posedge clk);
          #1;
          if (framesSent == base + 1 && cyc == lastStart + 5 * BIT_CLKS + 52) begin
            resetN = 1'b0;
            waitCycles(2);
            checkOutput("t6 reset data", 32'(dutData), 32'd0);
            checkOutput("t6 reset busy", 32'(dutBusy), 32'd0);
            checkOutput("t6 reset valid", 32'(dutValid), 32'd0);
            resetN = 1'b1;
            hit = 1'b1;
            break;
          end
        end
      end
    join
    checkOutput("t6 reset applied", 32'(hit), 32'd1);
    waitCycles(300);
    checkOutput("t6 frame dropped", 32'(riseCount - rises0), 32'd0);
    applyStimulus(8'h81, 1'b1);
    waitCycles(10);
    checkOutput("t6 byte", 32'(riseData), 32'h81);
    checkOutput("t6 rise count", 32'(riseCount - rises0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
